xor_pulse_driver: RTL and testbench
===================================

Name: xor_pulse_driver

Overview:
- Upstream stimulus and response stage for the basic_xor pulse-logic model.
- Accepts operand pairs over a valid/ready handshake. Encodes each 1 operand as a single edge (toggle) on a_out / b_out, then toggles gate_clk after enforced separations so the gate's hold windows are always met.
- Watches the gate's toggle-encoded output, checks it against a XOR b, and reports one result per operation.

Parameters:
- SEP_CYCLES, 3, system-clock cycles between consecutive pulses of one operation (a→b, a→gate_clk, b→gate_clk); legal range ≥1.
- RESP_TIMEOUT, 8, observation window in cycles after the gate_clk toggle; legal range ≥2.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  driver can accept an operand pair.
- in_a  in  1  operand a.
- in_b  in  1  operand b.
- a_out  out  1  toggle-encoded pulse to gate input a.
- b_out  out  1  toggle-encoded pulse to gate input b.
- gate_clk  out  1  toggle-encoded clock pulse to the gate.
- gate_out  in  1  toggle-encoded output from the gate.
- res_valid  out  1  one-cycle result strobe.
- res_bit  out  1  observed result: odd number of gate_out edges in the window.
- res_err  out  1  mismatch with expected result, or a stray edge occurred.
- busy  out  1  operation in progress; equals !in_ready.

Behaviour:
- Reset values: in_ready=1, a_out=0, b_out=0, gate_clk=0, res_valid=0, res_bit=0, res_err=0, busy=0. Internal state: FSM=IDLE, counter=0, edge count=0, stray=0.
- gate_out edge sampling: the prev-value register loads gate_out during reset, so no false edge is seen on reset exit. An edge is prev != gate_out, registered.
- Handshake: an accept is in_valid && in_ready on a posedge. in_ready is high only in IDLE. Operands are latched at the accept edge. No backpressure on results.
- All pulse outputs are registered; "toggle at edge N" means the output changes at posedge N. The accept edge is edge 0.
- FSM: IDLE → PH_A → PH_B → PH_CLK → OBS → IDLE.
  - A phase whose operand is 0 is skipped in zero cycles and produces no toggle.
  - PH_A: a_out toggles on entry; dwell SEP_CYCLES cycles.
  - PH_B: b_out toggles on entry; dwell SEP_CYCLES cycles.
  - PH_CLK: gate_clk toggles; go directly to OBS.
  - OBS: count gate_out edges (2-bit saturating) for RESP_TIMEOUT cycles.
- Toggle edges for S=SEP_CYCLES and T=RESP_TIMEOUT:
  - a=1, b=1: a at 0, b at S, gate_clk at 2S.
  - Exactly one operand 1: that operand at 0, gate_clk at S.
  - a=0, b=0: gate_clk at 0.
- Ordering: a always precedes b, matching the gate's state-1 path (a then b returns it to idle).
- Result: res_valid pulses for one cycle at gate_clk edge + T. At that same edge in_ready rises and the FSM enters IDLE. A new accept is possible on the next edge.
  - res_bit = edge count[0].
  - res_err = (edge count != (in_a ^ in_b ? 1 : 0)) | stray. Count 2 saturated is always an error.
  - stray and edge count clear when the result issues.
- Stray edges: a gate_out edge outside OBS sets the sticky stray flag, which is reported on the next result.
- Simultaneous stray edge and result issue: the edge is attributed to the next operation.
- Reset mid-operation: the operation is abandoned, all outputs return to reset values, and no result is issued. Any resulting 1→0 transitions on pulse outputs are real edges at the gate; the bench must re-initialise the gate after reset.
- Counter width: $clog2(max(SEP_CYCLES, RESP_TIMEOUT)+1).
- Elaboration error if SEP_CYCLES < 1 or RESP_TIMEOUT < 2.

Test Plan:
1. S=3, T=8, a=1, b=0, gate model toggles gate_out 5 cycles after gate_clk → a_out toggles at edge 0, gate_clk at edge 3, res_valid at edge 11 with res_bit=1, res_err=0.
2. a=1, b=1, gate model toggles nothing → a at 0, b at 3, gate_clk at 6, res at 14 with res_bit=0, res_err=0. Also check a_out/b_out separation is ≥3 cycles.
3. a=0, b=0, gate model faulted to toggle once → gate_clk at 0, res at 8 with res_bit=1, res_err=1.
4. a=0, b=1, gate_out never toggles → res_err=1 at edge 11. Then inject a gate_out edge while IDLE and run a=1, b=0 with a correct response → that result still has res_err=1 (stray); the following result is clean.
5. Assert rst at edge 4 of an a=1, b=1 operation → no res_valid; all outputs 0 the cycle after; in_ready=1; the next operation runs with nominal timing.
6. Back-to-back in_valid held high for 3 operations → accepts occur exactly one cycle after each res_valid; in_ready is never high in a non-IDLE state.

Source files
------------

// File: rtl/xor_pulse_driver_if.sv
// Operand and result bus for the XOR pulse driver.
//   in_valid/in_ready : operand-pair handshake (source -> driver)
//   in_a/in_b         : operand bits, latched by the driver on accept
//   res_valid         : one-cycle result strobe (no backpressure)
//   res_bit/res_err   : observed gate result and error flag
interface xor_pulse_driver_if;
  logic in_valid;
  logic in_ready;
  logic in_a;
  logic in_b;
  logic res_valid;
  logic res_bit;
  logic res_err;

  modport master (
    output in_valid, in_a, in_b,
    input  in_ready, res_valid, res_bit, res_err
  );

  modport slave (
    input  in_valid, in_a, in_b,
    output in_ready, res_valid, res_bit, res_err
  );
endinterface

// File: rtl/xor_pulse_driver.sv
// Stimulus/response stage for a toggle-encoded (pulse-logic) XOR gate.
// Each accepted operand pair is turned into edges on a_out / b_out (one
// edge per operand that is 1, a before b), followed by an edge on gate_clk
// after SEP_CYCLES of separation. The gate's toggle-encoded output is then
// observed for RESP_TIMEOUT cycles and one result is reported per operation.
//   clk, rst   : system clock, synchronous active-high reset
//   bus        : operand handshake and result strobe (slave side)
//   a_out      : toggle-encoded pulse to gate input a
//   b_out      : toggle-encoded pulse to gate input b
//   gate_clk   : toggle-encoded clock pulse to the gate
//   gate_out   : toggle-encoded output from the gate
//   busy       : operation in progress (inverse of in_ready)
module xor_pulse_driver #(
  parameter int SEP_CYCLES   = 3,
  parameter int RESP_TIMEOUT = 8
) (
  input  logic                clk,
  input  logic                rst,
  xor_pulse_driver_if.slave   bus,
  output logic                a_out,
  output logic                b_out,
  output logic                gate_clk,
  input  logic                gate_out,
  output logic                busy
);

  localparam int CNT_MAX = (SEP_CYCLES > RESP_TIMEOUT) ? SEP_CYCLES : RESP_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SEP_LD = CNT_W'(SEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] OBS_LD = CNT_W'(RESP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  generate
    if (SEP_CYCLES < 1 || RESP_TIMEOUT < 2) begin : g_bad_params
      $error("xor_pulse_driver: SEP_CYCLES must be >= 1 and RESP_TIMEOUT >= 2");
    end
  endgenerate

  // The clock-pulse phase is transient: the gate_clk toggle is fired on the
  // edge that leaves the previous phase, and the FSM lands directly in OBS.
  typedef enum logic [1:0] {IDLE, PH_A, PH_B, OBS} state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nx;
  logic             r_a;
  logic             r_b;
  logic             r_a_out;
  logic             r_b_out;
  logic             r_gclk;
  logic             r_gprev;
  logic [1:0]       r_ecnt;
  logic             r_stray;
  logic             r_res_valid;
  logic             r_res_bit;
  logic             r_res_err;

  logic w_accept;
  logic w_tog_a;
  logic w_tog_b;
  logic w_tog_g;
  logic w_issue;
  logic w_edge;
  logic w_cnt_edge;
  logic w_stray_edge;

  assign w_accept = (r_state == IDLE) && bus.in_valid;
  assign w_edge   = r_gprev ^ gate_out;
  // Edges count toward the result only strictly inside the window; an edge
  // coinciding with the result edge is charged to the next operation.
  assign w_cnt_edge   = w_edge && (r_state == OBS) && !w_issue;
  assign w_stray_edge = w_edge && !w_cnt_edge;

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_tog_a    = 1'b0;
    w_tog_b    = 1'b0;
    w_tog_g    = 1'b0;
    w_issue    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          // Operands are taken straight from the bus on the accept edge;
          // phases with a 0 operand are skipped without delay.
          if (bus.in_a) begin
            w_tog_a = 1'b1; w_state_nx = PH_A; w_cnt_nx = SEP_LD;
          end else if (bus.in_b) begin
            w_tog_b = 1'b1; w_state_nx = PH_B; w_cnt_nx = SEP_LD;
          end else begin
            w_tog_g = 1'b1; w_state_nx = OBS;  w_cnt_nx = OBS_LD;
          end
        end
      end
      PH_A: begin
        if (r_cnt != '0) begin
          w_cnt_nx = r_cnt - CNT_ONE;
        end else if (r_b) begin
          w_tog_b = 1'b1; w_state_nx = PH_B; w_cnt_nx = SEP_LD;
        end else begin
          w_tog_g = 1'b1; w_state_nx = OBS;  w_cnt_nx = OBS_LD;
        end
      end
      PH_B: begin
        if (r_cnt != '0) begin
          w_cnt_nx = r_cnt - CNT_ONE;
        end else begin
          w_tog_g = 1'b1; w_state_nx = OBS; w_cnt_nx = OBS_LD;
        end
      end
      OBS: begin
        if (r_cnt != '0) begin
          w_cnt_nx = r_cnt - CNT_ONE;
        end else begin
          w_issue = 1'b1; w_state_nx = IDLE; w_cnt_nx = '0;
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_cnt_nx   = '0;
      end
    endcase
  end

  // Operand latch and gate_out history: data only, no reset. The history
  // register also loads during reset so reset exit never looks like an edge.
  always_ff @(posedge clk) begin
    r_gprev <= gate_out;
    if (w_accept) begin
      r_a <= bus.in_a;
      r_b <= bus.in_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_a_out     <= 1'b0;
      r_b_out     <= 1'b0;
      r_gclk      <= 1'b0;
      r_ecnt      <= 2'd0;
      r_stray     <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_bit   <= 1'b0;
      r_res_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_a_out     <= r_a_out ^ w_tog_a;
      r_b_out     <= r_b_out ^ w_tog_b;
      r_gclk      <= r_gclk ^ w_tog_g;
      r_res_valid <= w_issue;
      if (w_issue) begin
        r_res_bit <= r_ecnt[0];
        r_res_err <= (r_ecnt != {1'b0, r_a ^ r_b}) | r_stray;
        r_ecnt    <= 2'd0;
        r_stray   <= w_stray_edge;
      end else begin
        if (w_cnt_edge && r_ecnt != 2'd3) r_ecnt <= r_ecnt + 2'd1;
        if (w_stray_edge) r_stray <= 1'b1;
      end
    end
  end

  assign a_out         = r_a_out;
  assign b_out         = r_b_out;
  assign gate_clk      = r_gclk;
  assign bus.in_ready  = (r_state == IDLE);
  assign busy          = (r_state != IDLE);
  assign bus.res_valid = r_res_valid;
  assign bus.res_bit   = r_res_bit;
  assign bus.res_err   = r_res_err;

endmodule

// File: tb/tb_xor_pulse_driver.sv
module tb_xor_pulse_driver;
  localparam int S = 3;
  localparam int T = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_out, b_out, gate_clk, busy;
  logic gate_out = 1'b0;

  xor_pulse_driver_if bus();

  xor_pulse_driver #(.SEP_CYCLES(S), .RESP_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .a_out(a_out), .b_out(b_out), .gate_clk(gate_clk),
    .gate_out(gate_out), .busy(busy)
  );

  always #5 clk = ~clk;

  // Number of posedges so far; at a negedge, changes made at posedge N show cyc == N.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int sig; int at; } tog_t;          // sig: 0=a_out 1=b_out 2=gate_clk
  typedef struct { int at; bit rbit; bit rerr; } res_t;
  tog_t tq[$];
  res_t rq[$];

  int n_vec = 0;
  int n_bad = 0;

  // Reference-model / gate-model shared state (each written by one process).
  int gate_d1 = 0, gate_d2 = 0;   // gate_out toggle delays after gate_clk (0 = none)
  int stray_req = 0;              // bumped to request one stray gate_out edge
  bit m_stray = 0;                // model: stray edge pending for next result
  int busy_lo = 0, busy_hi = 0;   // expected busy interval [lo, hi)
  int last_res = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Gate model: toggles gate_out a programmed number of cycles after each
  // gate_clk edge, and on request injects one stray edge.
  initial begin : gate_model
    logic g_prev;
    int t1, t2, s_done;
    g_prev = 1'b0; t1 = -1; t2 = -1; s_done = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        g_prev = gate_clk; t1 = -1; t2 = -1;
      end else begin
        if (gate_clk != g_prev) begin
          g_prev = gate_clk;
          t1 = (gate_d1 > 0) ? cyc + gate_d1 : -1;
          t2 = (gate_d2 > 0) ? cyc + gate_d2 : -1;
        end
        if (cyc == t1 || cyc == t2) gate_out = ~gate_out;
        if (s_done != stray_req) begin
          gate_out = ~gate_out;
          s_done = stray_req;
        end
      end
    end
  end

  // Monitor: pulse edges, results and handshake state, against the queues.
  initial begin : monitor
    logic pa, pb, pg;
    tog_t e;
    res_t r;
    pa = 1'b0; pb = 1'b0; pg = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pa = a_out; pb = b_out; pg = gate_clk;
      end else begin
        for (int s = 0; s < 3; s++) begin
          logic cur, prv;
          cur = (s == 0) ? a_out : (s == 1) ? b_out : gate_clk;
          prv = (s == 0) ? pa : (s == 1) ? pb : pg;
          if (cur != prv) begin
            if (tq.size() == 0) check("toggle_unexpected_sig", s, -1);
            else begin
              e = tq.pop_front();
              check("toggle_sig", s, e.sig);
              check("toggle_cycle", cyc, e.at);
            end
          end
        end
        if (tq.size() > 0 && cyc > tq[0].at) begin
          e = tq.pop_front();
          check("toggle_missing_at", cyc, e.at);
        end
        pa = a_out; pb = b_out; pg = gate_clk;

        if (bus.res_valid) begin
          if (rq.size() == 0) check("res_unexpected", cyc, -1);
          else begin
            r = rq.pop_front();
            check("res_cycle", cyc, r.at);
            check("res_bit", int'(bus.res_bit), int'(r.rbit));
            check("res_err", int'(bus.res_err), int'(r.rerr));
          end
        end else if (rq.size() > 0 && cyc > rq[0].at) begin
          r = rq.pop_front();
          check("res_missing_at", cyc, r.at);
        end

        check("busy_vs_ready", int'(busy), int'(!bus.in_ready));
        if (cyc >= busy_lo && cyc < busy_hi) check("ready_low_while_busy", int'(bus.in_ready), 0);
        if (cyc == busy_hi) check("ready_at_result", int'(bus.in_ready), 1);
      end
    end
  end

  task automatic inject_stray();
    m_stray = 1'b1;
    stray_req++;
    repeat (3) @(negedge clk);
  endtask

  // Issue one operation and push its expected pulse edges and result.
  // Called at a negedge. rst_at>0 resets the DUT at that edge of the operation.
  task automatic do_op(input bit a, input bit b, input int nd, input int d1,
                       input bit hold, input bit b2b, input int rst_at);
    int acc, g, rc;
    bit ok;
    gate_d1 = (nd >= 1) ? d1 : 0;
    gate_d2 = (nd >= 2) ? d1 + 2 : 0;
    bus.in_a = a; bus.in_b = b; bus.in_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (bus.in_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("accept_seen", int'(ok), 1);
    if (!ok) begin bus.in_valid = 1'b0; return; end
    acc = cyc + 1;
    if (b2b) check("b2b_accept_cycle", acc, last_res + 1);
    if (a) tq.push_back('{0, acc});
    if (b) tq.push_back('{1, a ? acc + S : acc});
    g  = acc + (a ? S : 0) + (b ? S : 0);
    tq.push_back('{2, g});
    rc = g + T;
    rq.push_back('{rc, bit'(nd & 1), (nd != int'(a ^ b)) || m_stray});
    m_stray = 1'b0;
    busy_lo = acc; busy_hi = rc;
    @(negedge clk);
    if (!hold) bus.in_valid = 1'b0;
    if (rst_at > 0) begin
      while (cyc < acc + rst_at - 1) @(negedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("rst_a_out", int'(a_out), 0);
      check("rst_b_out", int'(b_out), 0);
      check("rst_gate_clk", int'(gate_clk), 0);
      check("rst_res_valid", int'(bus.res_valid), 0);
      check("rst_res_bit", int'(bus.res_bit), 0);
      check("rst_res_err", int'(bus.res_err), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_in_ready", int'(bus.in_ready), 1);
      tq.delete(); rq.delete();
      busy_hi = cyc; m_stray = 1'b0;
      #1 rst = 1'b0;
      @(negedge clk);
      last_res = cyc;
      return;
    end
    while (cyc < rc) @(negedge clk);
    last_res = rc;
  endtask

  initial begin : stimulus
    bit prev_hold;
    bus.in_valid = 1'b0; bus.in_a = 1'b0; bus.in_b = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_in_ready", int'(bus.in_ready), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_a_out", int'(a_out), 0);
    check("reset_b_out", int'(b_out), 0);
    check("reset_gate_clk", int'(gate_clk), 0);
    check("reset_res_valid", int'(bus.res_valid), 0);
    #1 rst = 1'b0;
    @(negedge clk);

    // Directed cases
    do_op(1'b1, 1'b0, 1, 5, 1'b0, 1'b0, 0);   // correct single response
    do_op(1'b1, 1'b1, 0, 1, 1'b0, 1'b0, 0);   // a then b, no response
    do_op(1'b0, 1'b0, 1, 2, 1'b0, 1'b0, 0);   // faulted gate toggles
    do_op(1'b0, 1'b1, 0, 1, 1'b0, 1'b0, 0);   // missing response
    inject_stray();
    do_op(1'b1, 1'b0, 1, 3, 1'b0, 1'b0, 0);   // correct but stray pending
    do_op(1'b1, 1'b0, 1, 3, 1'b0, 1'b0, 0);   // clean again
    do_op(1'b1, 1'b1, 0, 1, 1'b0, 1'b0, 4);   // reset mid-operation
    do_op(1'b1, 1'b1, 0, 1, 1'b0, 1'b0, 0);   // nominal timing after reset
    do_op(1'b1, 1'b0, 1, 2, 1'b1, 1'b0, 0);   // back-to-back x3
    do_op(1'b0, 1'b1, 1, 1, 1'b1, 1'b1, 0);
    do_op(1'b1, 1'b1, 2, 1, 1'b0, 1'b1, 0);   // two edges: saturating error

    // Randomized operations
    prev_hold = 1'b0;
    for (int i = 0; i < 40; i++) begin
      bit a, b, hold;
      int nd;
      a = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      nd = ($urandom_range(0, 9) < 7) ? int'(a ^ b) : int'($urandom_range(0, 2));
      hold = (i != 39) && ($urandom_range(0, 3) == 0);
      if (!prev_hold) begin
        if ($urandom_range(0, 6) == 0) inject_stray();
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      do_op(a, b, nd, int'($urandom_range(1, 3)), hold, prev_hold, 0);
      prev_hold = hold;
    end
    bus.in_valid = 1'b0;

    repeat (T + 5) @(negedge clk);
    check("res_queue_drained", rq.size(), 0);
    check("toggle_queue_drained", tq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
